// File: rtl/spi_counter_pkg.sv
// spi_counter_pkg: shared constants for the SPI-controlled counter bank.
//   - SPI command byte field positions
//   - register-select encodings
//   - CTRL register bit positions
//   - SPI slave frame state encoding
package spi_counter_pkg;

  // Command byte layout: [7] write, [6:5] register select, [4:0] channel index.
  localparam int unsigned CmdBits  = 8;
  localparam int unsigned CmdWrBit = 7;
  localparam int unsigned CmdSelHi = 6;
  localparam int unsigned CmdSelLo = 5;
  localparam int unsigned CmdChHi  = 4;
  localparam int unsigned CmdChLo  = 0;

  // CTRL register bits.
  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlClrBit  = 1;
  localparam int unsigned CtrlModeBit = 2;
  localparam int unsigned CtrlAutoBit = 3;

  typedef enum logic [1:0] {
    SelCtrl  = 2'b00,
    SelCmp   = 2'b01,
    SelCount = 2'b10,
    SelRsvd  = 2'b11
  } reg_sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave front end running entirely in the clk domain.
// Synchronises sck/ss_n/mosi, detects sck and ss_n edges, counts frame bits and
// shifts the command byte and data word in (MSB first) and read data out.
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   sck, ss_n      SPI clock and slave select (asynchronous)
//   mosi, miso     SPI serial data in / out
//   cmd_stb        one-clk pulse: full command byte available on cmd
//   cmd            command byte, stable for the rest of the frame
//   wr_stb         one-clk pulse: full data word available on wr_data
//   wr_data        received data word
//   rd_data        read snapshot supplied by the bank, sent during data phase
module spi_slave_if
  import spi_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sck,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic               cmd_stb,
  output logic [CmdBits-1:0] cmd,
  output logic               wr_stb,
  output logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH-1:0]   rd_data
);

  localparam int unsigned FrameBits = CmdBits + WIDTH;
  localparam int unsigned CntW      = $clog2(FrameBits + 1);

  // Two synchroniser flops plus one history flop for edge detection.
  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q;

  logic sck_rise, sck_fall, ss_fall, ss_high, mosi_s;

  spi_state_e         state_q, state_d;
  logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CmdBits-1:0] cmd_q, cmd_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic [WIDTH-1:0]   tx_q, tx_d;
  logic               miso_q, miso_d;
  logic               cmd_stb_q, cmd_stb_d;
  logic               wr_stb_q, wr_stb_d;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_high  = ss_q[1];
  assign mosi_s   = mosi_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    cmd_stb_d = 1'b0;
    wr_stb_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d   = StCmd;
          bit_cnt_d = '0;
        end
      end
      StCmd: begin
        if (sck_rise) begin
          cmd_d     = {cmd_q[CmdBits-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(CmdBits - 1)) begin
            state_d   = StData;
            cmd_stb_d = 1'b1;
          end
        end
      end
      StData: begin
        if (sck_rise) begin
          rx_d      = {rx_q[WIDTH-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(FrameBits - 1)) begin
            state_d  = StDone;
            wr_stb_d = 1'b1;
          end
        end
        if (sck_fall) begin
          // First falling edge of the data phase presents the snapshot MSB.
          if (bit_cnt_q == CntW'(CmdBits)) begin
            miso_d = rd_data[WIDTH-1];
            tx_d   = {rd_data[WIDTH-2:0], 1'b0};
          end else begin
            miso_d = tx_q[WIDTH-1];
            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      StDone: begin
        // Frame complete; extra sck edges are ignored until ss_n rises.
      end
      default: state_d = StIdle;
    endcase

    // ss_n high ends (or aborts) any frame; an incomplete frame never strobes.
    if (ss_high) begin
      state_d   = StIdle;
      miso_d    = 1'b0;
      cmd_stb_d = 1'b0;
      wr_stb_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q     <= '0;
      ss_q      <= '0;
      mosi_q    <= '0;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      cmd_stb_q <= 1'b0;
      wr_stb_q  <= 1'b0;
    end else begin
      sck_q     <= {sck_q[1:0], sck};
      ss_q      <= {ss_q[1:0], ss_n};
      mosi_q    <= {mosi_q[0], mosi};
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      cmd_stb_q <= cmd_stb_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

  assign miso    = miso_q;
  assign cmd_stb = cmd_stb_q;
  assign cmd     = cmd_q;
  assign wr_stb  = wr_stb_q;
  assign wr_data = rx_q;

endmodule

// File: rtl/spi_counter_bank.sv
// spi_counter_bank: CH independent WIDTH-bit counters with compare-match,
// configured and read over an SPI mode-0 slave interface.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   sck, ss_n    SPI clock and slave select (asynchronous)
//   mosi, miso   SPI serial data in / out (miso is 0 while ss_n is high)
//   evt[CH]      per-channel count events (asynchronous, rising-edge counted)
//   match[CH]    per-channel registered compare-match pulse
module spi_counter_bank
  import spi_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sck,
  input  logic          ss_n,
  input  logic          mosi,
  output logic          miso,
  input  logic [CH-1:0] evt,
  output logic [CH-1:0] match
);

  logic                       cmd_stb, wr_stb, wr_en;
  logic [CmdBits-1:0]         cmd;
  logic [WIDTH-1:0]           wr_data, rd_q;
  reg_sel_e                   sel;
  logic [CmdChHi-CmdChLo:0]   ch_idx;

  // Per-channel read contributions OR-chained; an unmatched index yields 0.
  logic [WIDTH-1:0] rd_or [CH+1];

  assign sel    = reg_sel_e'(cmd[CmdSelHi:CmdSelLo]);
  assign ch_idx = cmd[CmdChHi:CmdChLo];
  assign wr_en  = wr_stb & cmd[CmdWrBit];
  assign rd_or[0] = '0;

  spi_slave_if #(
    .WIDTH(WIDTH)
  ) u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .sck    (sck),
    .ss_n   (ss_n),
    .mosi   (mosi),
    .miso   (miso),
    .cmd_stb(cmd_stb),
    .cmd    (cmd),
    .wr_stb (wr_stb),
    .wr_data(wr_data),
    .rd_data(rd_q)
  );

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [1:0]       evt_sync_q;
    logic             evt_prev_q;
    logic             en_q, mode_q, auto_q, clr_q, match_q, match_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, cmp_q, ctrl_v, rd_val;
    logic             ch_hit, wr_ctrl, wr_cmp, wr_cnt, evt_rise, inc, at_cmp;

    assign ch_hit   = (32'(ch_idx) == 32'(g));
    assign wr_ctrl  = wr_en & ch_hit & (sel == SelCtrl);
    assign wr_cmp   = wr_en & ch_hit & (sel == SelCmp);
    assign wr_cnt   = wr_en & ch_hit & (sel == SelCount);
    assign evt_rise = evt_sync_q[1] & ~evt_prev_q;
    assign inc      = en_q & (~mode_q | evt_rise);
    assign at_cmp   = (cnt_q == cmp_q);

    // SPI write > CLR > AUTO reload > increment. Match only on a real increment.
    always_comb begin
      cnt_d   = cnt_q;
      match_d = 1'b0;
      if (wr_cnt) begin
        cnt_d = wr_data;
      end else if (clr_q) begin
        cnt_d = '0;
      end else if (inc) begin
        match_d = at_cmp;
        cnt_d   = (auto_q && at_cmp) ? '0 : cnt_q + WIDTH'(1);
      end
    end

    // CLR is not stored; it always reads back 0.
    always_comb begin
      ctrl_v              = '0;
      ctrl_v[CtrlEnBit]   = en_q;
      ctrl_v[CtrlModeBit] = mode_q;
      ctrl_v[CtrlAutoBit] = auto_q;
    end

    always_comb begin
      rd_val = '0;
      unique case (sel)
        SelCtrl:  rd_val = ctrl_v;
        SelCmp:   rd_val = cmp_q;
        SelCount: rd_val = cnt_q;
        default:  rd_val = '0;
      endcase
    end

    assign rd_or[g+1] = rd_or[g] | (ch_hit ? rd_val : '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        evt_sync_q <= '0;
        evt_prev_q <= 1'b0;
        en_q       <= 1'b0;
        mode_q     <= 1'b0;
        auto_q     <= 1'b0;
        clr_q      <= 1'b0;
        cmp_q      <= '0;
        cnt_q      <= '0;
        match_q    <= 1'b0;
      end else begin
        evt_sync_q <= {evt_sync_q[0], evt[g]};
        evt_prev_q <= evt_sync_q[1];
        if (wr_ctrl) begin
          en_q   <= wr_data[CtrlEnBit];
          mode_q <= wr_data[CtrlModeBit];
          auto_q <= wr_data[CtrlAutoBit];
          clr_q  <= wr_data[CtrlClrBit];
        end else begin
          clr_q  <= 1'b0;
        end
        if (wr_cmp) begin
          cmp_q <= wr_data;
        end
        cnt_q   <= cnt_d;
        match_q <= match_d;
      end
    end

    assign match[g] = match_q;
  end

  // Read snapshot is captured once per frame, the clk after the command byte lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (cmd_stb) begin
      rd_q <= rd_or[CH];
    end
  end

endmodule

// File: tb/tb_spi_counter_bank.sv
module tb_spi_counter_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CH    = 2;
  localparam logic [1:0] SCtrl  = 2'b00;
  localparam logic [1:0] SCmp   = 2'b01;
  localparam logic [1:0] SCount = 2'b10;
  localparam logic [1:0] SRsvd  = 2'b11;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck   = 1'b0;
  logic          ss_n  = 1'b1;
  logic          mosi  = 1'b0;
  logic          miso;
  logic [CH-1:0] evt   = '0;
  logic [CH-1:0] match;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  spi_counter_bank #(
    .WIDTH(WIDTH),
    .CH   (CH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sck  (sck),
    .ss_n (ss_n),
    .mosi (mosi),
    .miso (miso),
    .evt  (evt),
    .match(match)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mk_cmd(input logic wr, input logic [1:0] sel,
                                        input logic [4:0] ch);
    return {wr, sel, ch};
  endfunction

  // One SPI frame; nd < 8 aborts after nd data bits. Edges are kept on 10 ns
  // boundaries, away from the rising clk edges at 5 ns offsets.
  task automatic spi_xfer(input logic [7:0] c, input logic [7:0] wd, input int nd,
                          output logic [7:0] rd);
    logic [7:0] cs, ds;
    cs = c;
    ds = wd;
    rd = '0;
    @(negedge clk);
    ss_n = 1'b0;
    #40;
    for (int i = 0; i < 8; i++) begin
      mosi = cs[7];
      cs   = cs << 1;
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    for (int i = 0; i < nd; i++) begin
      mosi = ds[7];
      ds   = ds << 1;
      #40;
      rd  = {rd[6:0], miso};
      sck = 1'b1;
      #40 sck = 1'b0;
    end
    #40;
    ss_n = 1'b1;
    mosi = 1'b0;
    #100;
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [4:0] ch, input logic [7:0] d);
    logic [7:0] unused_rd;
    spi_xfer(mk_cmd(1'b1, sel, ch), d, 8, unused_rd);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [4:0] ch,
                        input logic [7:0] exp);
    logic [7:0] got;
    exp_q.push_back(exp);
    spi_xfer(mk_cmd(1'b0, sel, ch), 8'h00, 8, got);
    chk(tag, 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic evt_pulse(input logic ch, output int hits);
    hits = 0;
    @(negedge clk);
    evt[ch] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (match[ch]) hits++;
    end
    evt[ch] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (match[ch]) hits++;
    end
  endtask

  initial begin
    logic [7:0] d;
    int         h, htot;
    logic       found;
    logic [7:0] cs;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset miso", 32'(miso), 32'd0);
    chk("reset match", 32'(match), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("reset ctrl0", SCtrl, 5'd0, 8'h00);
    rd_chk("reset cmp0", SCmp, 5'd0, 8'h00);
    rd_chk("reset count1", SCount, 5'd1, 8'h00);

    // Out-of-range channel and reserved select.
    wr_reg(SCmp, 5'd5, 8'hAA);
    wr_reg(SCtrl, 5'd5, 8'h01);
    wr_reg(SRsvd, 5'd0, 8'h77);
    rd_chk("ch5 cmp read", SCmp, 5'd5, 8'h00);
    rd_chk("ch5 ctrl read", SCtrl, 5'd5, 8'h00);
    rd_chk("rsvd read", SRsvd, 5'd0, 8'h00);
    rd_chk("cmp0 after ch5 write", SCmp, 5'd0, 8'h00);
    rd_chk("ctrl0 after ch5 write", SCtrl, 5'd0, 8'h00);

    // Auto-reload, period CMP+1.
    wr_reg(SCmp, 5'd0, 8'h05);
    rd_chk("cmp0 readback", SCmp, 5'd0, 8'h05);
    wr_reg(SCtrl, 5'd0, 8'h09);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (match[0]) found = 1'b1;
    end
    chk("auto first match", 32'(found), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("auto period k=%0d", k), 32'(match[0]), 32'((k % 6) == 0));
    end
    rd_chk("ctrl0 readback", SCtrl, 5'd0, 8'h09);
    exp_q.push_back(8'd1);
    spi_xfer(mk_cmd(1'b0, SCount, 5'd0), 8'h00, 8, d);
    chk("count0 within 0..5", 32'(d <= 8'd5), 32'(exp_q.pop_front()));

    // Disabled channel never matches.
    wr_reg(SCtrl, 5'd0, 8'h00);
    htot = 0;
    repeat (20) begin
      @(negedge clk);
      if (match[0]) htot++;
    end
    chk("no match when disabled", 32'(htot), 32'd0);
    wr_reg(SCount, 5'd0, 8'h42);

    // Event mode on channel 1 (CMP1 is 0, so the first increment matches).
    wr_reg(SCtrl, 5'd1, 8'h05);
    htot = 0;
    repeat (3) begin
      evt_pulse(1'b1, h);
      htot += h;
    end
    chk("ch1 match at cmp 0", 32'(htot), 32'd1);
    rd_chk("count1 after 3 evt", SCount, 5'd1, 8'h03);
    rd_chk("count0 unchanged", SCount, 5'd0, 8'h42);

    // CLR zeroes COUNT and reads back 0.
    wr_reg(SCtrl, 5'd1, 8'h02);
    rd_chk("count1 after clr", SCount, 5'd1, 8'h00);
    rd_chk("ctrl1 clr self-clear", SCtrl, 5'd1, 8'h00);

    // Wrap from 0xFF, match only on the increment out of CMP=0x10.
    wr_reg(SCmp, 5'd0, 8'h10);
    wr_reg(SCount, 5'd0, 8'hFF);
    wr_reg(SCtrl, 5'd0, 8'h05);
    evt_pulse(1'b0, h);
    chk("wrap no match", 32'(h), 32'd0);
    rd_chk("count0 wrapped", SCount, 5'd0, 8'h00);
    htot = 0;
    repeat (16) begin
      evt_pulse(1'b0, h);
      htot += h;
    end
    chk("no match below cmp", 32'(htot), 32'd0);
    rd_chk("count0 at cmp", SCount, 5'd0, 8'h10);
    evt_pulse(1'b0, h);
    chk("match leaving cmp", 32'(h), 32'd1);
    rd_chk("count0 past cmp", SCount, 5'd0, 8'h11);

    // Aborted write after 4 data bits.
    spi_xfer(mk_cmd(1'b1, SCmp, 5'd0), 8'h33, 4, d);
    chk("miso low after abort", 32'(miso), 32'd0);
    rd_chk("cmp0 after abort", SCmp, 5'd0, 8'h10);

    // Reset in the middle of a read frame.
    wr_reg(SCmp, 5'd1, 8'hFF);
    wr_reg(SCtrl, 5'd1, 8'h01);
    @(negedge clk);
    ss_n = 1'b0;
    #40;
    cs = mk_cmd(1'b0, SCmp, 5'd1);
    for (int i = 0; i < 8; i++) begin
      mosi = cs[7];
      cs   = cs << 1;
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    #40;
    chk("miso mid-read", 32'(miso), 32'd1);
    rst_n = 1'b0;
    #20;
    chk("miso in reset", 32'(miso), 32'd0);
    chk("match in reset", 32'(match), 32'd0);
    rst_n = 1'b1;
    #40;
    for (int i = 0; i < 4; i++) begin
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    #40;
    ss_n = 1'b1;
    mosi = 1'b0;
    #100;
    rd_chk("cmp1 after reset", SCmp, 5'd1, 8'h00);
    rd_chk("ctrl1 after reset", SCtrl, 5'd1, 8'h00);
    rd_chk("count1 after reset", SCount, 5'd1, 8'h00);
    rd_chk("cmp0 after reset", SCmp, 5'd0, 8'h00);
    wr_reg(SCmp, 5'd1, 8'h5A);
    rd_chk("cmp1 post-reset write", SCmp, 5'd1, 8'h5A);
    chk("match idle after reset", 32'(match), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
